// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with one 32-bit word per frame.
// Hits are answered in the request cycle. A miss reads one word from the
// memory port, fills the frame and then answers as a hit. A whole-cache
// flush is provided, along with saturating hit and fill counters.
//
// state | meaning
// IDLE  | serve hits from the frames; a miss moves to FETCH
// FETCH | memory read in flight; fill the indexed frame when iwait drops
module icache_direct #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             iflush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state_q, state_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  logic [31:0]      data_q [SETS];
  logic [31:0]      data_d [SETS];
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             unused_addr_lsb;

  assign idx             = imemaddr[IDX_W+1:2];
  assign req_tag         = imemaddr[31:IDX_W+2];
  assign unused_addr_lsb = ^imemaddr[1:0];

  // Lookup only counts as a hit while idle; FETCH never reports a hit.
  assign hit = (state_q == IDLE) && imemREN && valid_q[idx] && (tag_q[idx] == req_tag);

  // Fetch-port and memory-port outputs; everything is forced quiet during reset.
  always_comb begin
    ihit     = !nRST && hit;
    imemload = nRST ? 32'h0 : data_q[idx];
    iREN     = !nRST && (state_q == FETCH);
    iaddr    = (!nRST && (state_q == FETCH)) ? {imemaddr[31:2], 2'b00} : 32'h0;
  end

  // Next-state, frame update and counter logic. Flush clears valids first so a
  // fill on the same edge leaves its own frame valid.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (iflush) valid_d = '0;
    case (state_q)
      IDLE: begin
        if (hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        if (imemREN && !hit) state_d = FETCH;
      end
      FETCH: begin
        if (!iwait) begin
          valid_d[idx] = 1'b1;
          tag_d[idx]   = req_tag;
          data_d[idx]  = iload;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with synchronous reset; an in-flight fill is dropped on reset.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data storage; contents are don't-care until the valid bit is set.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
